// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if : bundle of everything the fetch stage exchanges with its
//               neighbours (hazard/branch control, instruction memory, IF/ID).
//
//   stall, flush, halt   hazard controls from downstream
//   br_taken, br_target  branch redirect from execute
//   instruction          word returned by instruction memory for pc_addr
//   pc_addr              current PC to instruction memory
//   if_id_*              IF/ID pipeline register contents to decode
//
// modport master : the fetch stage itself
// modport slave  : the surrounding pipeline / memory / test environment
// ----------------------------------------------------------------------------
interface if_stage_if #(
    parameter int WORD_LEN = 16
);
    logic                stall;
    logic                flush;
    logic                halt;
    logic                br_taken;
    logic [WORD_LEN-1:0] br_target;
    logic [WORD_LEN-1:0] instruction;
    logic [WORD_LEN-1:0] pc_addr;
    logic [WORD_LEN-1:0] if_id_instr;
    logic [WORD_LEN-1:0] if_id_pc;
    logic [WORD_LEN-1:0] if_id_pc_next;
    logic                if_id_valid;

    modport master (
        input  stall, flush, halt, br_taken, br_target, instruction,
        output pc_addr, if_id_instr, if_id_pc, if_id_pc_next, if_id_valid
    );

    modport slave (
        output stall, flush, halt, br_taken, br_target, instruction,
        input  pc_addr, if_id_instr, if_id_pc, if_id_pc_next, if_id_valid
    );
endinterface

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage pipeline.
//
// Owns the PC, presents it combinationally to a zero-latency instruction
// memory and registers the returned word into IF/ID. Per edge, in priority
// order: branch redirect > flush > stall > halt > normal fetch.
//
// Ports:
//   clk        rising-edge pipeline clock
//   rst        asynchronous, active-low reset
//   bus        if_stage_if.master (controls, imem, IF/ID outputs)
//   fetch_cnt  (IF_PERF_CNT_EN only) count of normal-fetch edges
//   stall_cnt  (IF_PERF_CNT_EN only) count of stall-hold edges
//
// Optional feature macro: IF_PERF_CNT_EN adds the two 32-bit performance
// counters; without it the stage has no counter ports or logic.
// ----------------------------------------------------------------------------
module if_stage #(
    parameter int                  WORD_LEN  = 16,
    parameter logic [WORD_LEN-1:0] RESET_PC  = '0,
    parameter logic [WORD_LEN-1:0] PC_STEP   = WORD_LEN'(4),
    parameter logic [WORD_LEN-1:0] NOP_INSTR = '0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
`endif
    if_stage_if.master  bus
);

    // Which rule this edge takes; decoded once so the PC, IF/ID and the
    // optional counters all agree on the same priority.
    typedef enum logic [2:0] {
        ACT_BRANCH,
        ACT_FLUSH,
        ACT_STALL,
        ACT_HALT,
        ACT_FETCH
    } act_e;

    act_e                act;
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] pc_inc;

    always_comb begin
        act = ACT_FETCH;
        if (bus.br_taken)   act = ACT_BRANCH;
        else if (bus.flush) act = ACT_FLUSH;
        else if (bus.stall) act = ACT_STALL;   // stall beats halt: IF/ID held
        else if (bus.halt)  act = ACT_HALT;
    end

    // Modulo 2^WORD_LEN: the carry out is simply dropped.
    assign pc_inc      = pc + PC_STEP;
    assign bus.pc_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc                <= RESET_PC;
            bus.if_id_instr   <= NOP_INSTR;
            bus.if_id_pc      <= '0;
            bus.if_id_pc_next <= '0;
            bus.if_id_valid   <= 1'b0;
        end else begin
            unique case (act)
                ACT_FETCH: begin
                    pc                <= pc_inc;
                    bus.if_id_instr   <= bus.instruction;
                    bus.if_id_pc      <= pc;
                    bus.if_id_pc_next <= pc_inc;
                    bus.if_id_valid   <= 1'b1;
                end
                ACT_STALL: ;   // everything holds
                default: begin
                    // Branch redirects the PC; flush and halt keep it so the
                    // same address is refetched. All three insert a bubble.
                    if (act == ACT_BRANCH) pc <= bus.br_target;
                    bus.if_id_instr   <= NOP_INSTR;
                    bus.if_id_pc      <= '0;
                    bus.if_id_pc_next <= '0;
                    bus.if_id_valid   <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (act == ACT_FETCH) fetch_cnt <= fetch_cnt + 32'd1;
            if (act == ACT_STALL) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage : directed bench for if_stage. A combinational instruction
// memory returns 16'h3101 @0, 16'h3200 @4 and addr ^ 16'hA5A5 elsewhere.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_if_stage;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    if_stage_if #(.WORD_LEN(W)) bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    if_stage #(.WORD_LEN(W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

    function automatic logic [W-1:0] imem(input logic [W-1:0] a);
        if (a == 16'h0000)      return 16'h3101;
        else if (a == 16'h0004) return 16'h3200;
        else                    return a ^ 16'hA5A5;
    endfunction

    assign bus.instruction = imem(bus.pc_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ifid(input string tag, input logic [W-1:0] ins, input logic [W-1:0] pc,
                        input logic [W-1:0] pcn, input logic v, input logic [W-1:0] pa);
        chk({tag, ".instr"},   32'(bus.if_id_instr),   32'(ins));
        chk({tag, ".pc"},      32'(bus.if_id_pc),      32'(pc));
        chk({tag, ".pc_next"}, 32'(bus.if_id_pc_next), 32'(pcn));
        chk({tag, ".valid"},   32'(bus.if_id_valid),   32'(v));
        chk({tag, ".pc_addr"}, 32'(bus.pc_addr),       32'(pa));
    endtask

    task automatic ctl(input logic s, input logic f, input logic h, input logic b,
                       input logic [W-1:0] t);
        bus.stall = s; bus.flush = f; bus.halt = h; bus.br_taken = b; bus.br_target = t;
    endtask

    initial begin
        ctl(0, 0, 0, 0, 16'h0000);
        // Reset held for two edges
        step(); step();
        ifid("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        rst = 1'b1;

        step(); ifid("e1", 16'h3101, 16'h0000, 16'h0004, 1'b1, 16'h0004);
        step(); ifid("e2", 16'h3200, 16'h0004, 16'h0008, 1'b1, 16'h0008);

        ctl(1, 0, 0, 0, 16'h0000);
        step(); ifid("stall1", 16'h3200, 16'h0004, 16'h0008, 1'b1, 16'h0008);
        step(); ifid("stall2", 16'h3200, 16'h0004, 16'h0008, 1'b1, 16'h0008);
        ctl(0, 0, 0, 0, 16'h0000);
        step(); ifid("unstall", 16'hA5AD, 16'h0008, 16'h000C, 1'b1, 16'h000C);

        // Branch beats stall
        ctl(1, 0, 0, 1, 16'h0028);
        step(); ifid("br_stall", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0028);
        ctl(0, 0, 0, 0, 16'h0000);
        step(); ifid("br_tgt", 16'hA58D, 16'h0028, 16'h002C, 1'b1, 16'h002C);

        // Redirect to 16, then flush refetches the same address
        ctl(0, 0, 0, 1, 16'h0010);
        step(); ifid("br16", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0010);
        ctl(0, 1, 0, 0, 16'h0000);
        step(); ifid("flush", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0010);
        ctl(0, 0, 0, 0, 16'h0000);
        step(); ifid("refetch", 16'hA5B5, 16'h0010, 16'h0014, 1'b1, 16'h0014);

        // Stall together with halt holds IF/ID; halt alone bubbles
        ctl(1, 0, 1, 0, 16'h0000);
        step(); ifid("stall_halt", 16'hA5B5, 16'h0010, 16'h0014, 1'b1, 16'h0014);
        ctl(0, 0, 1, 0, 16'h0000);
        step(); ifid("halt", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0014);
        step(); ifid("halt2", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0014);

        // Branch overrides halt; unaligned-looking target used verbatim
        ctl(0, 0, 1, 1, 16'hFFFC);
        step(); ifid("br_halt", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFFFC);
        ctl(0, 0, 0, 0, 16'h0000);
        step(); ifid("wrap", 16'h5A59, 16'hFFFC, 16'h0000, 1'b1, 16'h0000);
        step(); ifid("post_wrap", 16'h3101, 16'h0000, 16'h0004, 1'b1, 16'h0004);

        // Asynchronous reset between edges
        #2 rst = 1'b0;
        #1 ifid("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        step();
        rst = 1'b1;
        step(); ifid("after_rst", 16'h3101, 16'h0000, 16'h0004, 1'b1, 16'h0004);

`ifdef IF_PERF_CNT_EN
        // Fresh counters: 5 fetches, 3 stalls, 1 branch
        rst = 1'b0;
        #1 chk("cnt_rst_f", fetch_cnt, 32'd0);
        chk("cnt_rst_s", stall_cnt, 32'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step();
        ctl(1, 0, 0, 0, 16'h0000);
        for (int i = 0; i < 3; i++) step();
        ctl(0, 0, 0, 1, 16'h0040);
        step();
        ctl(0, 0, 0, 0, 16'h0000);
        chk("fetch_cnt", fetch_cnt, 32'd5);
        chk("stall_cnt", stall_cnt, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline. Owns the program counter, drives the combinational instruction memory address, and captures the returned word into the IF/ID pipeline register.
- Handles stall, flush and branch redirect from downstream hazard/branch logic.
- Sits directly upstream of the instruction memory and directly upstream of decode.

Parameters:
- WORD_LEN, 16, width of PC and instruction (matches `WORD_LEN).
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment per instruction (4 memory cells of 4 bits per instruction).
- NOP_INSTR, 16'h0000, instruction value written into IF/ID for a bubble.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- flush  in  1  squash IF/ID contents.
- halt  in  1  stop fetching; level-sensitive.
- br_taken  in  1  branch/jump resolved taken this cycle.
- br_target  in  WORD_LEN  redirect PC value.
- instruction  in  WORD_LEN  word from instruction memory for pc_addr (same cycle).
- pc_addr  out  WORD_LEN  current PC, to instruction memory addr.
- if_id_instr  out  WORD_LEN  registered instruction to decode.
- if_id_pc  out  WORD_LEN  PC of if_id_instr.
- if_id_pc_next  out  WORD_LEN  if_id_pc + PC_STEP (link/branch base).
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst=0, async, no clock needed):
  - pc=RESET_PC; if_id_instr=NOP_INSTR; if_id_pc=0; if_id_pc_next=0; if_id_valid=0.
  - Outputs hold these values while rst=0.
- pc_addr = pc register, combinational. instruction is treated as valid in the same cycle (zero-latency memory).
- Per rising edge, in priority order:
  1. br_taken=1: pc<=br_target; IF/ID<=bubble (instr=NOP_INSTR, valid=0, pc fields=0). Overrides stall, flush and halt.
  2. flush=1: IF/ID<=bubble; pc unchanged (the same address is refetched next cycle).
  3. stall=1: pc and all IF/ID fields hold.
  4. halt=1: pc holds; IF/ID<=bubble.
  5. Otherwise: IF/ID<={instruction, pc, pc+PC_STEP, valid=1}; pc<=pc+PC_STEP.
- Fetch-to-decode latency: 1 cycle. Steady-state throughput: 1 instruction/cycle.
- Arithmetic: pc+PC_STEP is modulo 2^WORD_LEN. 16'hFFFC+4 wraps to 16'h0000, with no flag. Memory truncation of the address is the memory's concern.
- br_target is not alignment-checked; it is used verbatim.
- A bubble never carries valid=1. if_id_pc_next is always if_id_pc+PC_STEP when valid=1.
- Reset asserted mid-operation: immediate return to reset values. The first fetch after deassertion uses RESET_PC on the first rising edge with rst=1.
- stall and halt together: stall wins (IF/ID holds, not bubbled).

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both async-reset to 0.
  - fetch_cnt increments on every edge taking rule 5.
  - stall_cnt increments on every edge taking rule 3.
  - Both wrap at 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then run: rst low 2 cycles, release, instruction mem returns 16'h3101 at addr 0 and 16'h3200 at addr 4 -> edge 1: if_id_instr=16'h3101, if_id_pc=0, if_id_pc_next=4, valid=1; edge 2: if_id_instr=16'h3200, if_id_pc=4; pc_addr=8.
- Stall: pc=8, stall=1 for 2 edges -> pc_addr stays 8, IF/ID unchanged both edges; on release, next edge captures instr@8, pc_addr=12.
- Branch beats stall: pc=12, br_taken=1, br_target=16'h0028, stall=1 -> pc_addr=16'h0028, if_id_valid=0, if_id_instr=NOP_INSTR; next edge captures instr@0x28 with valid=1.
- Flush only: pc=16, flush=1 -> if_id_valid=0, pc_addr stays 16; next edge captures instr@16, if_id_pc=16.
- Wrap and async reset: pc=16'hFFFC, normal edge -> pc_addr=0, if_id_pc=16'hFFFC, if_id_pc_next=0. Then drop rst between edges -> pc_addr=RESET_PC and if_id_valid=0 immediately, without an edge.
- IF_PERF_CNT_EN: 5 normal edges, 3 stall edges, 1 branch -> fetch_cnt=5, stall_cnt=3.
